fp_mul_sched: RTL and testbench
===============================

// Module: fp_mul_sched
// PURPOSE
//   Shares one sequenced IEEE-754 single-precision multiply datapath between NREQ requesters.
//   Round-robin arbiter plus an FSM that steps the datapath through its stages:
//   sign XOR, exponent add with bias removal, 24x24 mantissa multiply, normalise.
//   Holds each result until the winning requester accepts it.
//   Sits between the FP client blocks and the multiplier stages.
// PARAMETERS
//   NREQ     4  number of requesters (>=2)
//   IDW      2  requester id width, = $clog2(NREQ)
//   MUL_CYC  2  cycles spent in MUL state (>=1), models multi-cycle multiplier
// PORTS
//   clk          in   1        clock, all state on rising edge
//   rst_n        in   1        asynchronous active-low reset
//   req_valid    in   NREQ     per-requester operand valid
//   req_a        in   NREQ*32  operand A, requester i at [32*i+:32]
//   req_b        in   NREQ*32  operand B, requester i at [32*i+:32]
//   req_ready    out  NREQ     one-hot grant; handshake = req_valid[i]&req_ready[i]
//   resp_valid   out  1        result valid, held until accepted
//   resp_id      out  IDW      requester id that owns the result
//   resp_result  out  32       product {sign,exp[7:0],mant[22:0]}
//   resp_flags   out  4        {invalid,overflow,underflow,zero}
//   resp_ready   in   1        result consumer ready
//   busy         out  1        1 when state != IDLE
// BEHAVIOUR
//   Reset (async, rst_n=0)
//     - state=IDLE, rr_ptr=0; resp_valid=0, resp_id=0, resp_result=0, resp_flags=0, busy=0.
//     - req_ready=0 while in reset. An in-flight operation is discarded; no response issued.
//   FSM: IDLE -> EXP -> MUL (MUL_CYC cycles, down-counter) -> NORM -> RESP -> IDLE
//   IDLE
//     - Grant g = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
//     - req_ready = onehot(g) combinationally, only in IDLE and only if some req_valid=1.
//     - On the handshake cycle T: latch a, b, id=g and go to EXP. req_ready=0 in all other states.
//   EXP (T+1)
//     - s = a[31]^b[31].
//     - e = a[30:23] + b[30:23] - 127, computed signed 10-bit; no 8-bit wrap allowed.
//   MUL (T+2 .. T+1+MUL_CYC)
//     - p[47:0] = {1,a[22:0]} * {1,b[22:0]}.
//   NORM (T+2+MUL_CYC)
//     - p[47]=1: mant=p[46:24], e=e+1.
//     - p[47]=0: mant=p[45:23].
//     - Truncate; no rounding.
//   Special cases (NORM, in priority order)
//     - Either exp field==255 -> result 0x7FC00000, flags=4'b1000.
//     - Else either exp field==0 (zero/denormal, flushed) -> {s,31'b0}, flags=4'b0001.
//     - Else e>=255 -> {s,8'hFF,23'b0}, flags=4'b0100.
//     - Else e<=0 -> {s,31'b0}, flags=4'b0011.
//     - Else normal result, flags=0.
//   RESP (from T+3+MUL_CYC)
//     - resp_valid=1 with resp_id/result/flags registered and stable until resp_valid&resp_ready.
//     - On acceptance: resp_valid=0 next cycle, rr_ptr=(id+1) mod NREQ, go to IDLE.
//     - Latency: handshake to resp_valid = 3+MUL_CYC cycles (5 at default).
//   Simultaneous events
//     - A new request arriving in the cycle a response is accepted is not granted until the
//       following IDLE cycle: one bubble, back-to-back throughput = 4+MUL_CYC cycles per op.
//     - A requester dropping req_valid before grant is legal; only the IDLE-cycle value is sampled.
//   Invariants
//     - At most one req_ready bit set. resp_* never change while resp_valid=1 && !resp_ready.
// TESTING
//   1) Req0 a=0x3FC00000 b=0x3FC00000 (1.5*1.5) -> resp_result=0x40100000, flags=0, id=0,
//      resp_valid exactly 5 cycles after handshake.
//   2) Req2 a=0x40000000 b=0xC0400000 (2*-3) -> 0xC0C00000, flags=0, id=2.
//   3) a=0x7F000000 b=0x7F000000 -> 0x7F800000, flags=4'b0100;
//      a=0x00000000 b=0xC0400000 -> 0x80000000, flags=4'b0001;
//      a=0x7F800000 b=0x3F800000 -> 0x7FC00000, flags=4'b1000.
//   4) All four req_valid held high from reset -> grant order 0,1,2,3,0;
//      the grant cycle is the cycle after the previous acceptance.
//   5) resp_ready held 0 for 10 cycles -> resp_valid and resp_* stable and no new grant;
//      release -> accepted, next grant one cycle later.
//   6) Assert rst_n=0 in MUL state -> all outputs 0 immediately, no response after release,
//      next grant starts scanning at requester 0.

Source files
------------

// File: rtl/fp_mul_sched.sv
// fp_mul_sched: one sequenced IEEE-754 single-precision multiplier shared by NREQ
// requesters through a round-robin arbiter; each result is held until it is accepted.
module fp_mul_sched #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int MUL_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 resp_valid,
    output logic [IDW-1:0]       resp_id,
    output logic [31:0]          resp_result,
    output logic [3:0]           resp_flags,
    input  logic                 resp_ready,
    output logic                 busy
);
    localparam int CW = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXP,
        S_MUL,
        S_NORM,
        S_RESP
    } state_t;

    state_t state, state_nx;

    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    gnt_id;
    logic [IDW-1:0]    idx;
    logic              any_valid;
    logic [31:0]       a_arr [NREQ];
    logic [31:0]       b_arr [NREQ];

    logic [IDW-1:0]    id_r;
    logic [31:0]       a_r, b_r;
    logic              s_r;
    logic signed [9:0] e_r;
    logic [24:0]       p_r;
    logic [CW-1:0]     cnt;

    logic [47:0]       prod;
    logic              prod_unused;
    logic signed [9:0] e_n;
    logic [22:0]       mant_n;
    logic [31:0]       res_n;
    logic [3:0]        flg_n;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            a_arr[i] = req_a[i*32 +: 32];
            b_arr[i] = req_b[i*32 +: 32];
        end
    end

    // First valid requester scanning upward from rr_ptr, wrapping at NREQ.
    always_comb begin
        any_valid = 1'b0;
        gnt_id    = '0;
        idx       = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = IDW'((32'(rr_ptr) + i) % NREQ);
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                gnt_id    = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (any_valid) state_nx = S_EXP;
            S_EXP:   state_nx = S_MUL;
            S_MUL:   if (cnt == '0) state_nx = S_NORM;
            S_NORM:  state_nx = S_RESP;
            S_RESP:  if (resp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && state == S_IDLE && any_valid) begin
            req_ready[gnt_id] = 1'b1;
        end
        busy       = (state != S_IDLE);
        resp_valid = (state == S_RESP);
    end

    assign prod        = {1'b1, a_r[22:0]} * {1'b1, b_r[22:0]};
    assign prod_unused = ^prod[22:0];

    // p_r holds product bits [47:23]: bit 24 is the carry-out, the rest feed either alignment.
    always_comb begin
        e_n    = p_r[24] ? (e_r + 10'sd1) : e_r;
        mant_n = p_r[24] ? p_r[23:1] : p_r[22:0];
        res_n  = {s_r, e_n[7:0], mant_n};
        flg_n  = 4'b0000;
        if (a_r[30:23] == 8'hFF || b_r[30:23] == 8'hFF) begin
            res_n = 32'h7FC0_0000;
            flg_n = 4'b1000;
        end else if (a_r[30:23] == 8'h00 || b_r[30:23] == 8'h00) begin
            res_n = {s_r, 31'b0};
            flg_n = 4'b0001;
        end else if (e_n >= 10'sd255) begin
            res_n = {s_r, 8'hFF, 23'b0};
            flg_n = 4'b0100;
        end else if (e_n <= 10'sd0) begin
            res_n = {s_r, 31'b0};
            flg_n = 4'b0011;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            id_r        <= '0;
            a_r         <= '0;
            b_r         <= '0;
            s_r         <= 1'b0;
            e_r         <= '0;
            p_r         <= '0;
            cnt         <= '0;
            resp_id     <= '0;
            resp_result <= '0;
            resp_flags  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        a_r  <= a_arr[gnt_id];
                        b_r  <= b_arr[gnt_id];
                        id_r <= gnt_id;
                    end
                end
                S_EXP: begin
                    s_r <= a_r[31] ^ b_r[31];
                    e_r <= $signed({2'b00, a_r[30:23]}) + $signed({2'b00, b_r[30:23]}) - 10'sd127;
                    cnt <= CW'(MUL_CYC - 1);
                end
                S_MUL: begin
                    p_r <= prod[47:23];
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                S_NORM: begin
                    resp_id     <= id_r;
                    resp_result <= res_n;
                    resp_flags  <= flg_n;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        rr_ptr <= (id_r == IDW'(NREQ - 1)) ? '0 : id_r + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_sched.sv
// tb_fp_mul_sched: vector table plus arbitration, back-pressure and reset sequences,
// with a scoreboard filled at each grant and drained as responses are accepted.
`timescale 1ns/1ps
module tb_fp_mul_sched;
    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int MUL_CYC = 2;
    localparam int LAT     = 3 + MUL_CYC;
    localparam int NVEC    = 13;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*32-1:0]  req_a;
    logic [NREQ*32-1:0]  req_b;
    logic [NREQ-1:0]     req_ready;
    logic                resp_valid;
    logic [IDW-1:0]      resp_id;
    logic [31:0]         resp_result;
    logic [3:0]          resp_flags;
    logic                resp_ready;
    logic                busy;

    always #5 clk = ~clk;

    fp_mul_sched #(.NREQ(NREQ), .IDW(IDW), .MUL_CYC(MUL_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_result(resp_result), .resp_flags(resp_flags), .resp_ready(resp_ready), .busy(busy)
    );

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic [3:0]  flg;
        int          cyc;
    } exp_t;

    vec_t        vecs [NVEC];
    exp_t        sb [$];
    exp_t        ent;
    int          grant_q [$];
    logic [31:0] exp_res [NREQ];
    logic [3:0]  exp_flg [NREQ];
    logic [31:0] rr_b [NREQ];
    logic [31:0] rr_r [NREQ];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   g0;
    logic chk_gap = 1'b0, have_acc = 1'b0, seen_v = 1'b0;
    logic prev_v = 1'b0, prev_rdy = 1'b0;
    logic [IDW-1:0] prev_id;
    logic [31:0]    prev_res;
    logic [3:0]     prev_flg;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Response monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen_v   = 1'b0;
            prev_v   = 1'b0;
            prev_rdy = 1'b0;
            have_acc = 1'b0;
        end else begin
            if (req_ready != '0) check("req_ready_onehot", 32'($onehot(req_ready)), 32'd1);
            if (prev_v && !prev_rdy) begin
                check("hold_valid", 32'(resp_valid), 32'd1);
                check("hold_id", 32'(resp_id), 32'(prev_id));
                check("hold_result", resp_result, prev_res);
                check("hold_flags", 32'(resp_flags), 32'(prev_flg));
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back('{i, exp_res[i], exp_flg[i], cyc});
                    grant_q.push_back(i);
                    if (chk_gap && have_acc) check("grant_gap", 32'(cyc - acc_cyc), 32'd1);
                end
            end
            if (resp_valid && !seen_v) begin
                seen_v = 1'b1;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got id %0d result %h, expected no response", resp_id, resp_result);
                end else begin
                    check("latency", 32'(cyc - sb[0].cyc), 32'(LAT));
                end
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() != 0) begin
                    ent = sb.pop_front();
                    check("resp_id", 32'(resp_id), 32'(ent.id));
                    check("resp_result", resp_result, ent.res);
                    check("resp_flags", 32'(resp_flags), 32'(ent.flg));
                end
                acc_cyc  = cyc;
                have_acc = 1'b1;
                seen_v   = 1'b0;
            end
            prev_v   = resp_valid;
            prev_rdy = resp_ready;
            prev_id  = resp_id;
            prev_res = resp_result;
            prev_flg = resp_flags;
        end
    end

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic [3:0] flg);
        exp_res[id]       = res;
        exp_flg[id]       = flg;
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_valid[id]     = 1'b1;
    endtask

    task automatic wait_grant(input int id);
        logic ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (req_valid[id] && req_ready[id]) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: requester %0d got no grant, expected one within 40 cycles", id);
        end
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_grants(input int n);
        logic ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (grant_q.size() >= n) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL grants_timeout: got %0d grants, expected %0d", grant_q.size(), n);
        end
    endtask

    task automatic drain();
        logic ok = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, busy=%0b, expected 0 and idle", sb.size(), busy);
        end
    endtask

    task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic [3:0] flg);
        @(posedge clk);
        #1;
        set_req(id, a, b, res, flg);
        wait_grant(id);
        drain();
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, 32'({req_ready, resp_valid, busy, resp_id, resp_flags}), 32'd0);
        check({name, "_result"}, resp_result, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{0, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000};
        vecs[1]  = '{2, 32'h40000000, 32'hC0400000, 32'hC0C00000, 4'b0000};
        vecs[2]  = '{2, 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0100};
        vecs[3]  = '{3, 32'h00000000, 32'hC0400000, 32'h80000000, 4'b0001};
        vecs[4]  = '{0, 32'h7F800000, 32'h3F800000, 32'h7FC00000, 4'b1000};
        vecs[5]  = '{1, 32'h00800000, 32'h00800000, 32'h00000000, 4'b0011};
        vecs[6]  = '{2, 32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0100};
        vecs[7]  = '{3, 32'h7F000000, 32'h3F800000, 32'h7F000000, 4'b0000};
        vecs[8]  = '{0, 32'h7F400000, 32'h3FC00000, 32'h7F800000, 4'b0100};
        vecs[9]  = '{1, 32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000};
        vecs[10] = '{2, 32'h00800000, 32'hBF000000, 32'h80000000, 4'b0011};
        vecs[11] = '{3, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000};
        vecs[12] = '{0, 32'hBFC00000, 32'hBFC00000, 32'h40100000, 4'b0000};
        rr_b = '{32'h3F800000, 32'h40000000, 32'hBF800000, 32'h3F000000};
        rr_r = '{32'h3FC00000, 32'h40400000, 32'hBFC00000, 32'h3F400000};

        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset_outputs");
        rst_n = 1'b1;

        for (int k = 0; k < NVEC; k++) begin
            do_op(vecs[k].id, vecs[k].a, vecs[k].b, vecs[k].res, vecs[k].flg);
        end

        // Round-robin from reset with every requester asserted.
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        grant_q.delete();
        chk_gap = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 32'h3FC00000, rr_b[i], rr_r[i], 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_grants(5);
        @(posedge clk);
        #1;
        req_valid = '0;
        for (int k = 0; k < 5; k++) begin
            check("rr_order", (grant_q.size() > k) ? 32'(grant_q[k]) : 32'hFFFF_FFFF, 32'(k % NREQ));
        end
        drain();
        chk_gap = 1'b0;

        // Back-pressure: result held, competing request waits for acceptance.
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        set_req(1, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
        wait_grant(1);
        for (int k = 0; k < 20 && !resp_valid; k++) @(negedge clk);
        check("stall_resp_valid_rise", 32'(resp_valid), 32'd1);
        @(posedge clk);
        #1;
        set_req(3, 32'h40400000, 32'h40400000, 32'h41100000, 4'b0000);
        g0 = grant_q.size();
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("stall_no_grant", 32'(grant_q.size()), 32'(g0));
        check("stall_valid", 32'(resp_valid), 32'd1);
        chk_gap = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        wait_grant(3);
        drain();
        chk_gap = 1'b0;

        // Reset during MUL: operation dropped, pointer back to requester 0.
        do_op(1, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000);
        @(posedge clk);
        #1;
        set_req(2, 32'h40000000, 32'h40000000, 32'h40800000, 4'b0000);
        wait_grant(2);
        @(posedge clk);
        #1;
        check("busy_in_mul", 32'(busy), 32'd1);
        rst_n = 1'b0;
        sb.delete();
        grant_q.delete();
        for (int i = 0; i < NREQ; i++) set_req(i, 32'h3FC00000, rr_b[i], rr_r[i], 4'b0000);
        #1;
        check_outputs_zero("mid_op_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_grants(1);
        @(posedge clk);
        #1;
        req_valid = '0;
        check("post_reset_grant", (grant_q.size() > 0) ? 32'(grant_q[0]) : 32'hFFFF_FFFF, 32'd0);
        drain();
        repeat (5) @(posedge clk);
        check("post_reset_no_extra", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
